ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
// Instruction-fetch engine that reads from instruction memory, starting at the program counter.
// - Walks a fetch address, issues word reads to the instruction-memory port over a req/gnt/rvalid protocol.
// - Buffers returned words with their PCs in a small queue.
// - Hands instructions to decode over a valid/ready handshake.
// - A redirect (branch/jump target) flushes all in-flight and queued work.
// PARAMETERS
// ADDR_W    32            fetch address width
// DATA_W    32            instruction word width
// Q_DEPTH   2             fetch-queue entries (power of 2, >=2)
// RESET_PC  32'h0000_0000 fetch address after reset
// PORTS
// clk             in   1       clock, all state updates on rising edge
// rst             in   1       synchronous reset, active-high
// redirect_valid  in   1       load new fetch address, flush queue
// redirect_pc     in   ADDR_W  new fetch address (bits [1:0] ignored)
// imem_req        out  1       read request to instruction memory
// imem_addr       out  ADDR_W  word-aligned read address, stable while imem_req && !imem_gnt
// imem_gnt        in   1       request accepted this cycle
// imem_rvalid     in   1       read data valid (>=1 cycle after gnt)
// imem_rdata      in   DATA_W  read data
// instr_valid     out  1       queue head valid
// instr_ready     in   1       decode accepts head this cycle
// instr_data      out  DATA_W  queue head instruction
// instr_pc        out  ADDR_W  PC of queue head
// busy            out  1       request or response outstanding (state REQ/WAIT/DROP)
// BEHAVIOUR
// Reset values (sync, rst=1)
// - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, busy=0.
// - Internal: fpc=RESET_PC, queue count=0, state=IDLE.
// FSM states
// - IDLE: no request. Go to REQ when count < Q_DEPTH.
// - REQ: imem_req=1, imem_addr=fpc. On gnt: fpc<=fpc+4 (mod 2^ADDR_W, wraps FFFF_FFFC->0), go to WAIT.
// - WAIT: on rvalid, push {pc, rdata} into the queue, then go to REQ if (count after push/pop) < Q_DEPTH, else IDLE.
// - DROP: a granted request was orphaned by a redirect. Discard its rvalid, then go to REQ.
// - At most one request outstanding. Queue space is reserved at grant: issue only when count < Q_DEPTH.
// Queue output and handshake
// - Queue head is registered. instr_valid=(count!=0). Pop when instr_valid && instr_ready. Push and pop in the same cycle are legal.
// - Latency: with gnt in the same cycle as req and rvalid one cycle later, instr_valid rises 1 cycle after rvalid.
// - First instruction visible 3 cycles after rst falls (IDLE, REQ, WAIT).
// - Steady throughput: 1 instruction per 2 cycles.
// - Held output (valid && !ready): instr_data/instr_pc stable.
// Redirect (highest priority, any state)
// - fpc<=redirect_pc & ~3; queue count<=0, so instr_valid=0 the next cycle; any pop that cycle is ignored.
// - From IDLE: go to REQ.
// - From REQ without gnt that cycle: request withdrawn, stay in REQ with the new address (imem permits withdrawal).
// - From REQ with gnt that cycle: go to DROP.
// - From WAIT without rvalid: go to DROP. From WAIT with rvalid that cycle: data discarded, go to REQ.
// - From DROP: stay in DROP, fpc updated.
// Reset mid-operation
// - Queue, FSM and imem_req clear at the next edge.
// - An rvalid arriving after reset is ignored (IDLE/REQ states never push).
// STRUCTURE
// - mips_pkg: FSM state localparams (IDLE/REQ/WAIT/DROP) and the PC_STEP=4 constant.
// - Sub-module fetch_queue: sync FIFO of {ADDR_W+DATA_W} x Q_DEPTH.
//   Ports: push, pop, flush, din, dout, count. Registered head; flush has priority over push.
// - FSM, fpc register and issue logic stay in ifetch_unit.
// TESTING
// T1 reset/first fetch: rst 1->0, gnt tied 1, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000
//    -> imem_addr 0,4,8 in order; instr_pc=0, instr_data=32'hA5A5_0000 at cycle 3.
// T2 backpressure: instr_ready=0 for 10 cycles
//    -> exactly Q_DEPTH=2 words fetched (pc 0,4), imem_req low afterwards; head held stable; ready=1 resumes at 8.
// T3 redirect in WAIT: redirect_pc=32'h0000_0103 while response pending
//    -> stale rdata discarded (state DROP), next imem_addr=32'h0000_0100, queue empty before it.
// T4 simultaneous events: redirect + rvalid + instr_ready in the same cycle
//    -> no push, no pop, count=0 next cycle, next request at the redirect address.
// T5 wrap: redirect_pc=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 with matching instr_pc.
// T6 slow memory: gnt delayed 3 cycles, redirect on the 2nd wait cycle -> imem_addr switches before gnt; no DROP, no stale push.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the instruction-fetch slice.
//               Contents:
//                 fetch_state_t - fetch FSM state encoding (IDLE/REQ/WAIT/DROP)
//                 PC_STEP       - byte distance between consecutive words
//                 word_align()  - clears the byte-offset bits of an address
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request; waiting for queue space
    ST_REQ  = 2'd1,  // request driven, waiting for grant
    ST_WAIT = 2'd2,  // granted, waiting for read data
    ST_DROP = 2'd3   // granted request orphaned by a redirect
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

  // Force a byte address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO holding fetched {pc, instruction} entries.
//               The head entry is read straight out of the storage flops, so
//               it stays stable while it is not popped. flush beats push.
// Ports       :
//   clk    in   clock
//   rst    in   synchronous reset, active-high (clears storage and count)
//   push   in   write din at the tail
//   pop    in   discard the head (ignored when empty)
//   flush  in   empty the queue
//   din    in   WIDTH  entry to write
//   dout   out  WIDTH  head entry
//   count  out  CNT_W  number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full queue can still accept a write when the head leaves the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction-fetch engine. Walks a fetch PC, issues one word
//               read at a time over req/gnt/rvalid, buffers the returned words
//               with their PCs and presents them to decode over valid/ready.
//               A redirect reloads the fetch PC and flushes queued and
//               in-flight work.
// Ports       :
//   clk, rst        clock; synchronous active-high reset
//   redirect_valid  in   load redirect_pc as new fetch PC, flush queue
//   redirect_pc     in   ADDR_W  new fetch PC (bits [1:0] ignored)
//   imem_req        out  read request
//   imem_addr       out  ADDR_W  word-aligned read address
//   imem_gnt        in   request accepted this cycle
//   imem_rvalid     in   read data valid
//   imem_rdata      in   DATA_W  read data
//   instr_valid     out  queue head valid
//   instr_ready     in   decode takes the head this cycle
//   instr_data      out  DATA_W  head instruction
//   instr_pc        out  ADDR_W  head PC
//   busy            out  request or response outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              Q_DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy
);

  localparam int CNT_W = $clog2(Q_DEPTH) + 1;
  localparam int QW    = ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(Q_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_CX = (CNT_W + 1)'(Q_DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fpc;       // next address to request
  logic [ADDR_W-1:0] pend_pc;   // address of the granted, outstanding read
  logic [CNT_W-1:0]  q_count;
  logic [QW-1:0]     q_dout;
  logic              q_push;
  logic              q_pop;
  logic [CNT_W:0]    cnt_after; // queue occupancy after this cycle's push/pop

  // Redirect cancels any pop this cycle; the flush empties the queue anyway.
  assign q_pop     = instr_valid && instr_ready && !redirect_valid;
  assign q_push    = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign cnt_after = {1'b0, q_count} + (CNT_W + 1)'(1) - {{CNT_W{1'b0}}, q_pop};

  // Outputs decode straight from flops.
  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = fpc;
  assign busy        = (state != ST_IDLE);
  assign instr_valid = (q_count != '0);
  assign instr_pc    = q_dout[QW-1:DATA_W];
  assign instr_data  = q_dout[DATA_W-1:0];

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (Q_DEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .din   ({pend_pc, imem_rdata}),
    .dout  (q_dout),
    .count (q_count)
  );

  // Queue space is reserved at issue: only one read is ever outstanding and
  // REQ is entered only with room for its result, so a push never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      fpc     <= RESET_PC;
      pend_pc <= '0;
    end else if (redirect_valid) begin
      fpc <= redirect_pc & ~ADDR_W'(3);
      unique case (state)
        ST_IDLE: state <= ST_REQ;
        // Ungranted request is simply withdrawn and re-driven at the target.
        ST_REQ:  state <= imem_gnt ? ST_DROP : ST_REQ;
        ST_WAIT: state <= imem_rvalid ? ST_REQ : ST_DROP;
        ST_DROP: state <= ST_DROP;
        default: state <= ST_IDLE;
      endcase
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (q_count < DEPTH_C) begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_gnt) begin
            pend_pc <= fpc;
            fpc     <= fpc + STEP;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= (cnt_after < DEPTH_CX) ? ST_REQ : ST_IDLE;
          end
        end
        ST_DROP: begin
          // Swallow the orphaned response; the queue was flushed, so there
          // is room for a new request.
          if (imem_rvalid) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit. A memory responder with
//               adjustable grant delay and read latency returns
//               rdata = addr ^ 32'hA5A5_0000. Expected grant addresses and
//               delivered PCs are queued when a fetch stream starts and
//               popped by monitors on every grant / decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_gnt = 0;
  int n_pop = 0;
  int gnt_delay = 0;
  int rlat = 1;
  int wcnt = 0;
  int pcnt = 0;
  logic [31:0] paddr = '0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  always #5 clk = ~clk;

  ifetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .Q_DEPTH  (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .busy           (busy)
  );

  // ---------------- memory responder ----------------
  always_comb imem_gnt = imem_req && (wcnt >= gnt_delay);

  always @(posedge clk) begin
    if (!imem_req || imem_gnt) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
    imem_rvalid <= 1'b0;
    if (pcnt != 0) begin
      pcnt <= pcnt - 1;
      if (pcnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= paddr ^ KEY;
      end
    end
    if (imem_req && imem_gnt) begin
      if (rlat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= imem_addr ^ KEY;
      end else begin
        paddr <= imem_addr;
        pcnt  <= rlat - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected fetch stream from base: base, base+4, ... (32-bit wrap).
  task automatic set_stream(input logic [31:0] base);
    exp_addr.delete();
    exp_pc.delete();
    for (int i = 0; i < 64; i++) begin
      exp_addr.push_back(base + 32'(4 * i));
      exp_pc.push_back(base + 32'(4 * i));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors (inputs settled, before the next edge) ----------------
  always @(negedge clk) begin
    if (!rst && !redirect_valid) begin
      if (imem_req && imem_gnt) begin
        n_gnt++;
        if (exp_addr.size() != 0) check("gnt_addr", imem_addr, exp_addr.pop_front());
        else check("gnt_sb_underflow", 32'(exp_addr.size()), 32'd1);
      end
      if (instr_valid && instr_ready) begin
        n_pop++;
        if (exp_pc.size() != 0) begin
          logic [31:0] e;
          e = exp_pc.pop_front();
          check("pop_pc", instr_pc, e);
          check("pop_data", instr_data, e ^ KEY);
        end else begin
          check("pop_sb_underflow", 32'(exp_pc.size()), 32'd1);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    int g0;
    logic found;

    // T1: reset values and first fetch
    set_stream(32'h0);
    repeat (3) tick();
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_data", instr_data, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    p0 = n_pop;
    tick();
    check("t1_c1_req", imem_req, 1'b1);
    tick();
    check("t1_c2_valid", instr_valid, 1'b0);
    tick();
    check("t1_c3_valid", instr_valid, 1'b1);
    check("t1_c3_pc", instr_pc, 32'h0);
    check("t1_c3_data", instr_data, 32'hA5A5_0000);
    repeat (8) tick();
    check("t1_throughput", 32'(n_pop - p0), 32'd4);

    // T2: backpressure (reset lands mid-operation)
    rst = 1'b1;
    instr_ready = 1'b0;
    repeat (3) tick();
    set_stream(32'h0);
    g0 = n_gnt;
    rst = 1'b0;
    repeat (3) tick();
    check("t2_c3_valid", instr_valid, 1'b1);
    for (int c = 4; c <= 10; c++) begin
      tick();
      check("t2_hold_pc", instr_pc, 32'h0);
      check("t2_hold_data", instr_data, 32'hA5A5_0000);
    end
    check("t2_gnt_count", 32'(n_gnt - g0), 32'd2);
    check("t2_req_low", imem_req, 1'b0);
    check("t2_idle", busy, 1'b0);
    instr_ready = 1'b1;
    repeat (6) tick();
    check("t2_resumed", 32'(n_gnt - g0 >= 3), 32'd1);

    // T3: redirect while a response is pending
    rlat = 2;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t3_found_gnt", found, 1'b1);
    tick();
    check("t3_wait_busy", busy, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    set_stream(32'h0000_0100);
    tick();
    redirect_valid = 1'b0;
    check("t3_drop_empty", instr_valid, 1'b0);
    check("t3_drop_noreq", imem_req, 1'b0);
    check("t3_drop_busy", busy, 1'b1);
    tick();
    check("t3_req", imem_req, 1'b1);
    check("t3_addr", imem_addr, 32'h0000_0100);
    check("t3_empty", instr_valid, 1'b0);
    rlat = 1;
    repeat (8) tick();

    // T4: redirect + rvalid + ready in the same cycle
    rst = 1'b1;
    instr_ready = 1'b0;
    repeat (3) tick();
    set_stream(32'h0);
    rst = 1'b0;
    repeat (4) tick();
    check("t4_pre_valid", instr_valid, 1'b1);
    check("t4_pre_rvalid", imem_rvalid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    instr_ready    = 1'b1;
    set_stream(32'h0000_0200);
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed", instr_valid, 1'b0);
    check("t4_req", imem_req, 1'b1);
    check("t4_addr", imem_addr, 32'h0000_0200);
    repeat (8) tick();

    // T5: address wrap
    p0 = n_pop;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    set_stream(32'hFFFF_FFF8);
    tick();
    redirect_valid = 1'b0;
    repeat (14) tick();
    check("t5_wrapped", 32'(n_pop - p0 >= 3), 32'd1);

    // T6: slow grant, redirect while request still ungranted
    rst = 1'b1;
    gnt_delay = 3;
    repeat (3) tick();
    set_stream(32'h0);
    rst = 1'b0;
    repeat (2) tick();
    check("t6_c2_req", imem_req, 1'b1);
    check("t6_c2_addr", imem_addr, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0403;
    set_stream(32'h0000_0400);
    tick();
    redirect_valid = 1'b0;
    check("t6_c3_req", imem_req, 1'b1);
    check("t6_c3_addr", imem_addr, 32'h0000_0400);
    repeat (3) tick();
    check("t6_c6_valid", instr_valid, 1'b1);
    check("t6_c6_pc", instr_pc, 32'h0000_0400);
    check("t6_c6_data", instr_data, 32'hA5A5_0400);
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
